// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-2 Booth multiplier sequencer.
// The optional BOOTH_EARLY_EXIT_EN feature is handled in booth_mult_ctrl.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_SHIFT,
    OP_ADD,
    OP_SUB
  } step_op_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/booth_step_decode.sv
// Booth step decode: {Q[0], q_m1} to add/subtract/shift-only.
module booth_step_decode
  import booth_pkg::*;
(
  input  logic     q0_i,
  input  logic     q_m1_i,
  output step_op_e op_o
);

  always_comb begin
    op_o = OP_SHIFT;
    case ({q0_i, q_m1_i})
      2'b01:   op_o = OP_ADD;
      2'b10:   op_o = OP_SUB;
      default: op_o = OP_SHIFT;
    endcase
  end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Radix-2 Booth signed multiplier sequencer, one step per cycle.
// Define BOOTH_EARLY_EXIT_EN to finish early once the remaining steps are shift-only.
module booth_mult_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_width(WIDTH);
  localparam int RW = 2 * WIDTH + 2;

  state_e state_q, state_d;
  logic signed [WIDTH:0] a_q, a_d;
  logic signed [WIDTH:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic qm1_q, qm1_d;
  logic [CW-1:0] cnt_q, cnt_d;

  step_op_e op;
  logic signed [WIDTH:0] sum;
  logic signed [RW-1:0] acc;
  logic signed [RW-1:0] shifted;
  logic last;

  booth_step_decode u_dec (
    .q0_i   (q_q[0]),
    .q_m1_i (qm1_q),
    .op_o   (op)
  );

  always_comb begin
    sum = a_q;
    case (op)
      OP_ADD:  sum = a_q + m_q;
      OP_SUB:  sum = a_q - m_q;
      default: sum = a_q;
    endcase
    acc = {sum, q_q, qm1_q};
  end

`ifdef BOOTH_EARLY_EXIT_EN
  logic [WIDTH-1:0] mask;
  logic early;

  // Uniform low bits mean every remaining step is shift-only.
  always_comb begin
    mask    = ~({WIDTH{1'b1}} << cnt_q);
    early   = ((q_q ^ {WIDTH{qm1_q}}) & mask) == '0;
    shifted = early ? (acc >>> cnt_q) : (acc >>> 1);
    last    = early || (cnt_q == CW'(1));
  end
`else
  always_comb begin
    shifted = acc >>> 1;
    last    = (cnt_q == CW'(1));
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = '0;
          m_d     = {multiplicand[WIDTH-1], multiplicand};
          q_d     = multiplier;
          qm1_d   = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = CALC;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        {a_d, q_d, qm1_d} = shifted;
        cnt_d = last ? '0 : cnt_q - CW'(1);
        if (last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = {a_q[WIDTH-1:0], q_q};

endmodule
